// File: rtl/ct_split.sv
// Packet-aware splitter/multicaster: routes each packet to the ports in the mask sampled on its first beat.
// Latency: zero, all outputs are combinational from inputs and route/done state.
// Backpressure: a beat is consumed only once every routed port has taken it; ports that already took it are masked off.
module ct_split #(
    parameter int RADIX   = 2,
    parameter int WIDTH   = 8,
    parameter int EOP_LOC = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic [RADIX-1:0] i_mask,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [RADIX-1:0] o_valid,
    input  logic [RADIX-1:0] i_ready
);

    typedef enum logic {
        S_SOP  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [RADIX-1:0] route, route_nxt;
    logic [RADIX-1:0] done, done_nxt;

    logic [RADIX-1:0] rt;
    logic [RADIX-1:0] acc;
    logic             in_vld;
    logic             bc;
    logic             eop;

    // Outputs are forced idle while reset is held, independent of the flops.
    assign in_vld = i_valid & reset_n;
    assign eop    = i_data[EOP_LOC];
    assign rt     = (state == S_SOP) ? i_mask : route;
    assign o_data = i_data;

    always_comb begin
        o_valid = {RADIX{in_vld}} & rt & ~done;
        acc     = o_valid & i_ready;
        bc      = in_vld & ((rt & ~(done | acc)) == '0);
        o_ready = bc;
    end

    always_comb begin
        state_nxt = state;
        route_nxt = route;
        done_nxt  = done | acc;
        if (bc) begin
            done_nxt = '0;
            case (state)
                S_SOP: begin
                    // Single-beat packets never leave S_SOP and leave the route untouched.
                    if (!eop) begin
                        route_nxt = i_mask;
                        state_nxt = S_BODY;
                    end
                end
                S_BODY: begin
                    if (eop) begin
                        state_nxt = S_SOP;
                    end
                end
                default: state_nxt = S_SOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_SOP;
            route <= '0;
            done  <= '0;
        end else begin
            state <= state_nxt;
            route <= route_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ct_split.sv
// Directed checks of reset/unicast/multicast/backpressure/drop/reset-mid-packet, then a
// randomized phase scored per output port against a packet-level reference.
module tb_ct_split;

    localparam int RADIX = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic [RADIX-1:0] i_mask;
    logic             o_ready;
    logic [WIDTH-1:0] o_data;
    logic [RADIX-1:0] o_valid;
    logic [RADIX-1:0] i_ready;

    int n_tests;
    int n_fail;
    bit sb_en;

    logic [WIDTH-1:0] exp_q [RADIX][$];
    logic [RADIX-1:0] prev_pend;
    logic [WIDTH-1:0] prev_data;

    ct_split #(.RADIX(RADIX), .WIDTH(WIDTH), .EOP_LOC(0)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .i_data (i_data),
        .i_valid(i_valid),
        .i_mask (i_mask),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each acceptance on port k must carry the next beat queued for k.
    always @(negedge clk) begin
        if (sb_en && reset_n) begin
            if (!i_valid) chk("idle_vld", {28'd0, o_valid}, 32'd0);
            for (int k = 0; k < RADIX; k++) begin
                if (prev_pend[k]) begin
                    chk($sformatf("hold_vld%0d", k), {31'd0, o_valid[k]}, 32'd1);
                    chk($sformatf("hold_dat%0d", k), {24'd0, o_data}, {24'd0, prev_data});
                end
                if (o_valid[k] && i_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL port%0d_extra: got 0x%0h expected no beat", k, o_data);
                    end else begin
                        chk($sformatf("port%0d_dat", k), {24'd0, o_data}, {24'd0, exp_q[k].pop_front()});
                    end
                end
            end
            prev_pend <= o_valid & ~i_ready;
            prev_data <= o_data;
        end else begin
            prev_pend <= '0;
        end
    end

    initial begin
        logic [6:0]       seq;
        logic [RADIX-1:0] pmask;
        logic [WIDTH-1:0] d;
        int               len;
        bit               got;
        int               wait_cnt;

        n_tests   = 0;
        n_fail    = 0;
        sb_en     = 1'b0;
        prev_pend = '0;
        prev_data = '0;

        // Reset holds outputs low even with a valid beat present.
        reset_n = 1'b0;
        i_valid = 1'b1;
        i_mask  = 4'hF;
        i_data  = 8'h01;
        i_ready = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", {28'd0, o_valid}, 32'h0);
        chk("rst_rdy", {31'd0, o_ready}, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("rel_vld", {28'd0, o_valid}, 32'hF);
        i_ready = 4'hF;
        #1;
        chk("rel_rdy", {31'd0, o_ready}, 32'h1);
        step();

        // Unicast: body-beat masks must be ignored.
        i_data = 8'h10; i_mask = 4'b0100;
        @(negedge clk);
        chk("uni0_vld", {28'd0, o_valid}, 32'h4);
        chk("uni0_rdy", {31'd0, o_ready}, 32'h1);
        step();
        i_data = 8'h12; i_mask = 4'b0001;
        @(negedge clk);
        chk("uni1_vld", {28'd0, o_valid}, 32'h4);
        chk("uni1_rdy", {31'd0, o_ready}, 32'h1);
        step();
        i_data = 8'h15;
        @(negedge clk);
        chk("uni2_vld", {28'd0, o_valid}, 32'h4);
        chk("uni2_rdy", {31'd0, o_ready}, 32'h1);
        step();
        i_data = 8'h17;
        @(negedge clk);
        chk("uni_sop_vld", {28'd0, o_valid}, 32'h1);
        step();

        // Staggered multicast.
        i_data = 8'h21; i_mask = 4'b1010; i_ready = 4'b0010;
        @(negedge clk);
        chk("mc0_vld", {28'd0, o_valid}, 32'hA);
        chk("mc0_rdy", {31'd0, o_ready}, 32'h0);
        step();
        i_ready = 4'b1000;
        @(negedge clk);
        chk("mc1_vld", {28'd0, o_valid}, 32'h8);
        chk("mc1_rdy", {31'd0, o_ready}, 32'h1);
        step();

        // Backpressure hold.
        i_data = 8'h55; i_mask = 4'b0001; i_ready = 4'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_vld", {28'd0, o_valid}, 32'h1);
            chk("bp_rdy", {31'd0, o_ready}, 32'h0);
            chk("bp_dat", {24'd0, o_data}, 32'h55);
            step();
        end
        i_ready = 4'b0001;
        @(negedge clk);
        chk("bp_done_rdy", {31'd0, o_ready}, 32'h1);
        step();

        // Zero-mask drop, then a normal packet.
        i_data = 8'h30; i_mask = 4'h0; i_ready = 4'h0;
        @(negedge clk);
        chk("drop0_rdy", {31'd0, o_ready}, 32'h1);
        chk("drop0_vld", {28'd0, o_valid}, 32'h0);
        step();
        i_data = 8'h33; i_mask = 4'hF;
        @(negedge clk);
        chk("drop1_rdy", {31'd0, o_ready}, 32'h1);
        chk("drop1_vld", {28'd0, o_valid}, 32'h0);
        step();
        i_data = 8'h35; i_mask = 4'b1000; i_ready = 4'b1000;
        @(negedge clk);
        chk("post_drop_vld", {28'd0, o_valid}, 32'h8);
        chk("post_drop_rdy", {31'd0, o_ready}, 32'h1);
        step();

        // Reset mid-packet: the next beat is a fresh SOP.
        i_data = 8'h40; i_mask = 4'b0010; i_ready = 4'hF;
        @(negedge clk);
        chk("mid0_vld", {28'd0, o_valid}, 32'h2);
        step();
        reset_n = 1'b0;
        i_data = 8'h42; i_mask = 4'b0100;
        @(negedge clk);
        chk("mid_rst_vld", {28'd0, o_valid}, 32'h0);
        chk("mid_rst_rdy", {31'd0, o_ready}, 32'h0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_sop_vld", {28'd0, o_valid}, 32'h4);
        step();
        i_data = 8'h43;
        @(negedge clk);
        chk("mid_eop_vld", {28'd0, o_valid}, 32'h4);
        step();
        i_valid = 1'b0;
        step();

        // Randomized packets scored per port.
        sb_en = 1'b1;
        seq   = '0;
        for (int p = 0; p < 250; p++) begin
            len   = $urandom_range(1, 4);
            pmask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_valid = 1'b0;
                    i_ready = 4'($urandom);
                    step();
                end
                d = {seq, (b == len - 1) ? 1'b1 : 1'b0};
                seq++;
                for (int k = 0; k < RADIX; k++)
                    if (pmask[k]) exp_q[k].push_back(d);
                i_valid  = 1'b1;
                i_data   = d;
                i_mask   = (b == 0) ? pmask : 4'($urandom);
                got      = 1'b0;
                wait_cnt = 0;
                while (!got && wait_cnt < 500) begin
                    i_ready = 4'($urandom);
                    @(negedge clk);
                    got = o_ready;
                    step();
                    wait_cnt++;
                end
                if (!got) chk("beat_timeout", 32'd0, 32'd1);
            end
        end
        i_valid = 1'b0;
        i_ready = 4'h0;
        repeat (4) step();
        sb_en = 1'b0;
        for (int k = 0; k < RADIX; k++)
            chk($sformatf("port%0d_left", k), exp_q[k].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
